vote_percent_ctrl: RTL and testbench



---
 rtl/vote_percent_ctrl.sv | 140 ++++++++++++++
 tb/tb_vote_percent_ctrl.sv | 206 ++++++++++++++++++++
 2 files changed

// File: rtl/vote_percent_ctrl.sv
// Vote percentage controller: snapshots per-candidate counts, finds leader/tie,
// then time-shares one combinational divider to produce floored percentages.

module division #(
  parameter int unsigned WIDTH = 8
) (
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  output logic [WIDTH-1:0] Res
);
  always_comb begin
    Res = '0;
    if (B != '0) Res = A / B;
  end
endmodule

module vote_percent_ctrl #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned NCAND = 4
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      start,
  input  logic [NCAND*WIDTH-1:0]    votes_flat,
  output logic                      busy,
  output logic                      done,
  output logic [NCAND*7-1:0]        pct_flat,
  output logic [$clog2(NCAND)-1:0]  winner,
  output logic                      tie,
  output logic                      zero_err
);
  localparam int unsigned CW = $clog2(NCAND);
  localparam int unsigned DW = WIDTH + 7;
  localparam int unsigned TW = WIDTH + CW;

  typedef enum logic [2:0] {IDLE, SUM, CHECK, LOAD, CAP, DONE} state_t;

  state_t           state;
  logic [WIDTH-1:0] snap [NCAND];
  logic [TW-1:0]    total;
  logic [WIDTH-1:0] maxv;
  logic [CW-1:0]    idx;
  logic [DW-1:0]    a_reg;
  logic [DW-1:0]    b_reg;
  logic [DW-1:0]    res;
  logic             last;
  logic             unused_res;

  division #(.WIDTH(DW)) u_div (
    .A   (a_reg),
    .B   (b_reg),
    .Res (res)
  );

  // quotient is bounded by 100, so only the low 7 bits are ever meaningful
  assign unused_res = ^res[DW-1:7];
  assign last       = (idx == CW'(NCAND-1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      busy     <= 1'b0;
      done     <= 1'b0;
      pct_flat <= '0;
      winner   <= '0;
      tie      <= 1'b0;
      zero_err <= 1'b0;
      total    <= '0;
      maxv     <= '0;
      idx      <= '0;
      a_reg    <= '0;
      b_reg    <= '0;
      for (int unsigned i = 0; i < NCAND; i++) snap[i] <= '0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            for (int unsigned i = 0; i < NCAND; i++)
              snap[i] <= votes_flat[i*WIDTH +: WIDTH];
            pct_flat <= '0;
            winner   <= '0;
            tie      <= 1'b0;
            zero_err <= 1'b0;
            total    <= '0;
            maxv     <= '0;
            idx      <= '0;
            busy     <= 1'b1;
            state    <= SUM;
          end
        end
        SUM: begin
          total <= total + TW'(snap[idx]);
          if (snap[idx] > maxv) begin
            maxv   <= snap[idx];
            winner <= idx;
            tie    <= 1'b0;
          end else if (snap[idx] == maxv && snap[idx] != '0) begin
            tie <= 1'b1;
          end
          if (last) begin
            idx   <= '0;
            state <= CHECK;
          end else begin
            idx <= idx + 1'b1;
          end
        end
        CHECK: begin
          if (total == '0) begin
            zero_err <= 1'b1;
            done     <= 1'b1;
            busy     <= 1'b0;
            state    <= DONE;
          end else begin
            idx   <= '0;
            state <= LOAD;
          end
        end
        LOAD: begin
          a_reg <= DW'(snap[idx]) * DW'(100);
          b_reg <= DW'(total);
          state <= CAP;
        end
        CAP: begin
          pct_flat[idx*7 +: 7] <= res[6:0];
          if (last) begin
            done  <= 1'b1;
            busy  <= 1'b0;
            state <= DONE;
          end else begin
            idx   <= idx + 1'b1;
            state <= LOAD;
          end
        end
        DONE:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_vote_percent_ctrl.sv
// Scoreboard bench for vote_percent_ctrl: driver queues expected results, monitor checks on done.

module tb_vote_percent_ctrl;
  logic        clk;
  logic        rst_n;
  logic        start;
  logic [31:0] votes_flat;
  logic        busy;
  logic        done;
  logic [27:0] pct_flat;
  logic [1:0]  winner;
  logic        tie;
  logic        zero_err;

  int checks   = 0;
  int failures = 0;

  typedef struct {
    logic [27:0] pct;
    logic [1:0]  w;
    logic        t;
    logic        z;
    int          edges;
    time         t0;
  } exp_t;

  exp_t sb[$];

  vote_percent_ctrl #(.WIDTH(8), .NCAND(4)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .start      (start),
    .votes_flat (votes_flat),
    .busy       (busy),
    .done       (done),
    .pct_flat   (pct_flat),
    .winner     (winner),
    .tie        (tie),
    .zero_err   (zero_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] expv);
    checks++;
    if (act !== expv) begin
      failures++;
      $display("FAIL %s actual=%0d expected=%0d", nm, act, expv);
    end
  endtask

  function automatic logic [31:0] pack(input int v0, input int v1, input int v2, input int v3);
    return {8'(v3), 8'(v2), 8'(v1), 8'(v0)};
  endfunction

  function automatic exp_t mk(input int p0, input int p1, input int p2, input int p3,
                              input int w, input int t, input int z);
    exp_t e;
    e.pct   = {7'(p3), 7'(p2), 7'(p1), 7'(p0)};
    e.w     = 2'(w);
    e.t     = 1'(t);
    e.z     = 1'(z);
    e.edges = (z != 0) ? 5 : 13;
    e.t0    = 0;
    return e;
  endfunction

  // Monitor
  int   busy_cnt = 0;
  logic busy_q   = 1'b0;
  logic done_q   = 1'b0;
  exp_t me;

  always @(negedge clk) begin
    if (busy && !busy_q) busy_cnt = 1;
    else if (busy) busy_cnt++;
    busy_q = busy;
    if (done_q) chk("done_pulse", done, 0);
    done_q = done;
    if (done) begin
      chk("sb_nonempty", (sb.size() != 0), 1);
      if (sb.size() != 0) begin
        me = sb.pop_front();
        chk("pct_flat", pct_flat, me.pct);
        chk("winner", winner, me.w);
        chk("tie", tie, me.t);
        chk("zero_err", zero_err, me.z);
        chk("latency", ($time - me.t0 - 5) / 10, me.edges);
        chk("busy_cycles", busy_cnt, me.edges);
        chk("busy_at_done", busy, 0);
      end
    end
  end

  task automatic wait_done();
    bit got = 0;
    for (int i = 0; i < 60 && !got; i++) begin
      @(negedge clk);
      if (done) got = 1;
    end
    chk("done_timeout", got, 1);
  endtask

  task automatic do_run(input int v0, input int v1, input int v2, input int v3,
                        input int p0, input int p1, input int p2, input int p3,
                        input int w, input int t, input int z);
    exp_t e;
    @(negedge clk);
    votes_flat = pack(v0, v1, v2, v3);
    start      = 1'b1;
    @(posedge clk);
    e    = mk(p0, p1, p2, p3, w, t, z);
    e.t0 = $time;
    sb.push_back(e);
    @(negedge clk);
    start = 1'b0;
    wait_done();
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog actual=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    exp_t e;
    bit   seen;
    rst_n      = 1'b0;
    start      = 1'b0;
    votes_flat = '0;
    repeat (3) @(negedge clk);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_pct", pct_flat, 0);
    chk("rst_winner", winner, 0);
    chk("rst_tie", tie, 0);
    chk("rst_zero_err", zero_err, 0);
    rst_n = 1'b1;
    @(negedge clk);
    chk("idle_busy_after_rst", busy, 0);

    // start held high across two runs, votes changed mid-run
    votes_flat = pack(10, 20, 30, 40);
    start      = 1'b1;
    @(posedge clk);
    e    = mk(10, 20, 30, 40, 3, 0, 0);
    e.t0 = $time;
    sb.push_back(e);
    repeat (3) @(negedge clk);
    votes_flat = pack(255, 255, 255, 255);
    wait_done();
    @(negedge clk);
    chk("idle_cycle_busy", busy, 0);
    @(posedge clk);
    e    = mk(25, 25, 25, 25, 0, 1, 0);
    e.t0 = $time;
    sb.push_back(e);
    @(negedge clk);
    start = 1'b0;
    chk("busy_after_reaccept", busy, 1);
    wait_done();

    do_run(0, 0, 0, 0,   0, 0, 0, 0,     0, 0, 1);
    do_run(1, 1, 1, 0,   33, 33, 33, 0,  0, 1, 0);
    do_run(0, 0, 7, 0,   0, 0, 100, 0,   2, 0, 0);
    do_run(7, 0, 0, 2,   77, 0, 0, 22,   0, 0, 0);

    // reset during the third CAP
    @(negedge clk);
    votes_flat = pack(10, 20, 30, 40);
    start      = 1'b1;
    @(posedge clk);
    e    = mk(10, 20, 30, 40, 3, 0, 0);
    e.t0 = $time;
    sb.push_back(e);
    @(negedge clk);
    start = 1'b0;
    repeat (10) @(posedge clk);
    @(negedge clk);
    chk("pct1_before_abort", pct_flat[13:7], 20);
    chk("winner_before_abort", winner, 3);
    rst_n = 1'b0;
    #1;
    chk("abort_pct", pct_flat, 0);
    chk("abort_winner", winner, 0);
    chk("abort_busy", busy, 0);
    chk("abort_done", done, 0);
    void'(sb.pop_back());
    @(negedge clk);
    rst_n = 1'b1;
    seen  = 0;
    repeat (20) begin
      @(negedge clk);
      if (done) seen = 1;
    end
    chk("no_done_after_abort", seen, 0);
    do_run(2, 6, 2, 0,   20, 60, 20, 0,  1, 0, 0);

    repeat (5) @(negedge clk);
    chk("sb_empty", sb.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
